// File: rtl/kernel_pkg.sv
// Shared widths, mode encoding and the output saturate/ReLU helper for the
// kernel processing element.
package kernel_pkg;

  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;

  typedef enum logic [1:0] {
    MODE_CONV1 = 2'b00,
    MODE_MAX   = 2'b01,
    MODE_MAC   = 2'b10,
    MODE_RSVD  = 2'b11
  } kernel_mode_t;

  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef struct packed {
    logic         en;
    logic         init;
    kernel_mode_t mode;
    logic         bias_en;
  } op_ctrl_t;

  typedef struct packed {
    logic        we;
    logic [31:0] idx;
  } wr_ctrl_t;

  typedef struct packed {
    logic          sat;
    logic [DW-1:0] data;
  } out_t;

  // Rescale Q.(2*FRAC) to Q.FRAC, clamp to DW signed, optional ReLU.
  // sat reports only a clamp that is visible on the returned data.
  function automatic out_t sat_relu(input logic signed [ACC_W-1:0] a, input logic relu);
    logic signed [ACC_W-1:0] sh;
    out_t o;
    sh    = a >>> FRAC;
    o.sat = 1'b0;
    if (sh > OUT_MAX) begin
      o.data = OUT_MAX[DW-1:0];
      o.sat  = 1'b1;
    end else if (sh < OUT_MIN) begin
      o.data = relu ? '0 : OUT_MIN[DW-1:0];
      o.sat  = !relu;
    end else begin
      o.data = (relu && sh[ACC_W-1]) ? '0 : sh[DW-1:0];
    end
    return o;
  endfunction

endpackage

// File: rtl/kernel_delay_line.sv
// Fixed-depth register delay line with asynchronous active-low clear.
module kernel_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/kernel_pe.sv
// Kernel processing element: fixed-point MAC / running max over operands from
// synchronous memories, with result writes aligned to the accumulator.
module kernel_pe
  import kernel_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          init,
  input  logic [1:0]    mode,
  input  logic          bias_en,
  input  logic          write_enable,
  input  logic [31:0]   result_idx,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] weight_in,
  output logic          wr_en,
  output logic [31:0]   wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          sat_flag
);

  op_ctrl_t op_in, op_d;
  wr_ctrl_t wr_in, wr_d;

  assign op_in = '{en: en, init: init, mode: kernel_mode_t'(mode), bias_en: bias_en};
  assign wr_in = '{we: write_enable, idx: result_idx};

  kernel_delay_line #(.W($bits(op_ctrl_t)), .DEPTH(READ_LAT)) u_op_dly (
    .clk(clk), .rstn(rstn), .d(op_in), .q(op_d)
  );

  // One extra stage: an operand seen with op_d lands in acc one edge later.
  kernel_delay_line #(.W($bits(wr_ctrl_t)), .DEPTH(READ_LAT+1)) u_wr_dly (
    .clk(clk), .rstn(rstn), .d(wr_in), .q(wr_d)
  );

  logic signed [ACC_W-1:0] acc, acc_next, base;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, data_ext;
  logic signed [2*DW-1:0]  product;
  kernel_mode_t            mode_r, eff_mode;
  out_t                    out;

  assign product  = $signed(data_in) * $signed(weight_in);
  assign prod_ext = {{(ACC_W-2*DW){product[2*DW-1]}}, product};
  assign bias_ext = {{(ACC_W-DW-FRAC){weight_in[DW-1]}}, weight_in, {FRAC{1'b0}}};
  assign data_ext = {{(ACC_W-DW-FRAC){data_in[DW-1]}}, data_in, {FRAC{1'b0}}};

  always_comb begin
    eff_mode = op_d.init ? op_d.mode : mode_r;
    base     = acc;
    if (op_d.init) base = (op_d.mode == MODE_MAX) ? ACC_MIN : '0;
    acc_next = base;
    case (eff_mode)
      MODE_CONV1, MODE_MAC: begin
        acc_next = base + (op_d.en ? prod_ext : '0) + (op_d.bias_en ? bias_ext : '0);
      end
      MODE_MAX: begin
        if (op_d.en && (data_ext > base)) acc_next = data_ext;
      end
      default: acc_next = base;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc    <= '0;
      mode_r <= MODE_CONV1;
    end else begin
      acc <= acc_next;
      if (op_d.init) mode_r <= op_d.mode;
    end
  end

  assign out     = sat_relu(acc, (mode_r == MODE_CONV1) || (mode_r == MODE_MAC));
  assign wr_data = out.data;
  assign wr_en   = wr_d.we;
  assign wr_addr = wr_d.idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 sat_flag <= 1'b0;
    else if (wr_en && out.sat) sat_flag <= 1'b1;
  end

endmodule
